// File: rtl/m_stage_pkg.sv
// m_stage_pkg: shared encodings and types for the MIPS memory stage.
//   - GRF write-data select codes (WD_*)
//   - memory access size codes (MT_*)
//   - default DM geometry
//   - E/M pipeline register layout
package m_stage_pkg;

  localparam int DM_WORDS_DEF = 3072;  // 12 KiB of 32-bit words
  localparam int DM_AW_DEF    = 12;    // word-index width

  typedef enum logic [1:0] {
    WD_MEM = 2'b00,
    WD_ALU = 2'b01,
    WD_PC8 = 2'b10
  } wd_sel_e;

  // MT_RSV decodes exactly like MT_W everywhere.
  typedef enum logic [1:0] {
    MT_W   = 2'b00,
    MT_H   = 2'b01,
    MT_B   = 2'b10,
    MT_RSV = 2'b11
  } mem_type_e;

  typedef struct packed {
    logic [31:0] result;
    logic [31:0] rt;
    logic [31:0] pcn;
    logic [31:0] op;
    logic [4:0]  a3;
    logic        reg_write;
    logic        mem_write;
    logic [1:0]  mem_type;
    logic        load_signed;
  } em_reg_t;

endpackage

// File: rtl/m_stage_if.sv
// m_stage_if: E -> M pipeline bundle.
//   master: E stage (drives the *_E_o fields)
//   slave : M stage (captures them into the E/M register)
interface m_stage_if;
  logic [31:0] result_E_o;
  logic [31:0] rt_E_o;
  logic [31:0] PCn_E_o;
  logic [31:0] OP_E_o;
  logic [4:0]  A3_E_o;
  logic        regWrite_E_o;
  logic        memWrite_E_o;
  logic [1:0]  memType_E_o;
  logic        loadSigned_E_o;

  modport master (
    output result_E_o, rt_E_o, PCn_E_o, OP_E_o, A3_E_o,
           regWrite_E_o, memWrite_E_o, memType_E_o, loadSigned_E_o
  );
  modport slave (
    input  result_E_o, rt_E_o, PCn_E_o, OP_E_o, A3_E_o,
           regWrite_E_o, memWrite_E_o, memType_E_o, loadSigned_E_o
  );
endinterface

// File: rtl/m_stage_dm_byte_unit.sv
// dm_byte_unit: combinational DM lane logic.
//   addr_lo     : byte offset within the word
//   mem_type    : access size (MT_*)
//   load_signed : sign-extend half/byte loads
//   rdata       : current DM word
//   st_data     : store data (low bits used for half/byte)
//   ld_data     : extended load value, 0 when misaligned
//   wdata       : read-modify-write merged word
//   aligned     : access satisfies its natural alignment
module dm_byte_unit
  import m_stage_pkg::*;
(
  input  logic [1:0]  addr_lo,
  input  logic [1:0]  mem_type,
  input  logic        load_signed,
  input  logic [31:0] rdata,
  input  logic [31:0] st_data,
  output logic [31:0] ld_data,
  output logic [31:0] wdata,
  output logic        aligned
);

  logic [15:0] half_v;
  logic [7:0]  byte_v;
  logic [4:0]  lane;

  always_comb begin
    aligned = 1'b1;
    ld_data = rdata;
    wdata   = st_data;
    half_v  = addr_lo[1] ? rdata[31:16] : rdata[15:0];
    lane    = {addr_lo, 3'b000};
    byte_v  = rdata[lane +: 8];
    case (mem_type)
      MT_H: begin
        aligned = ~addr_lo[0];
        ld_data = {{16{load_signed & half_v[15]}}, half_v};
        wdata   = addr_lo[1] ? {st_data[15:0], rdata[15:0]}
                             : {rdata[31:16], st_data[15:0]};
      end
      MT_B: begin
        ld_data = {{24{load_signed & byte_v[7]}}, byte_v};
        wdata   = rdata;
        wdata[lane +: 8] = st_data[7:0];
      end
      default: aligned = (addr_lo == 2'b00);  // word and reserved
    endcase
    if (!aligned) ld_data = '0;
  end

endmodule

// File: rtl/m_stage.sv
// m_stage: MIPS memory stage. Holds the E/M register and the data memory.
//   clk, reset        : clock, async active-low reset (also clears DM)
//   GRF_WDsel         : write-data select of the instruction now in M
//   e_if (slave)      : E-stage fields captured every edge
//   W_forward/A3/regWrite : W-stage write-back, used for store-data forwarding
//   *_M_o             : registered fields and load data toward W
//   M_forward/A3/regWrite : M-stage forwarding bus to D and E
//   dm_we/addr/wdata  : DM write observation
//   align_err         : sticky misaligned-access flag
module m_stage
  import m_stage_pkg::*;
#(
  parameter int DM_WORDS = DM_WORDS_DEF,
  parameter int DM_AW    = DM_AW_DEF
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [1:0]  GRF_WDsel,
  m_stage_if.slave    e_if,
  input  logic [31:0] W_forward,
  input  logic [4:0]  W_A3,
  input  logic        W_regWrite,
  output logic [31:0] memory_M_o,
  output logic [31:0] result_M_o,
  output logic [31:0] PCn_M_o,
  output logic [31:0] OP_M_o,
  output logic [4:0]  A3_M_o,
  output logic        regWrite_M_o,
  output logic [31:0] M_forward,
  output logic [4:0]  M_A3,
  output logic        M_regWrite,
  output logic        dm_we,
  output logic [31:0] dm_addr,
  output logic [31:0] dm_wdata,
  output logic        align_err
);

  localparam logic [29:0] DM_LIMIT = 30'(DM_WORDS);

  em_reg_t     m_q;
  logic [31:0] dm [DM_WORDS];

  logic [DM_AW-1:0] word_idx;
  logic             in_range;
  logic [31:0]      rdata;
  logic [31:0]      st_data;
  logic             st_fwd;
  logic             aligned;
  logic             is_load;

  // E/M register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) m_q <= '0;
    else        m_q <= '{result:      e_if.result_E_o,
                         rt:          e_if.rt_E_o,
                         pcn:         e_if.PCn_E_o,
                         op:          e_if.OP_E_o,
                         a3:          e_if.A3_E_o,
                         reg_write:   e_if.regWrite_E_o,
                         mem_write:   e_if.memWrite_E_o,
                         mem_type:    e_if.memType_E_o,
                         load_signed: e_if.loadSigned_E_o};
  end

  assign word_idx = m_q.result[DM_AW+1:2];
  assign in_range = (m_q.result[31:2] < DM_LIMIT);
  assign rdata    = in_range ? dm[word_idx] : '0;

  // A load that writes the register a store in M reads has only reached W;
  // its value arrives here instead of through E's forwarding.
  assign st_fwd  = W_regWrite && (W_A3 != 5'd0) && (W_A3 == m_q.op[20:16])
                   && m_q.mem_write;
  assign st_data = st_fwd ? W_forward : m_q.rt;

  dm_byte_unit u_byte (
    .addr_lo     (m_q.result[1:0]),
    .mem_type    (m_q.mem_type),
    .load_signed (m_q.load_signed),
    .rdata       (rdata),
    .st_data     (st_data),
    .ld_data     (memory_M_o),
    .wdata       (dm_wdata),
    .aligned     (aligned)
  );

  assign dm_we   = m_q.mem_write && aligned && in_range;
  assign dm_addr = m_q.result;

  // Only real loads (write-back from memory) count toward the alignment
  // flag; ALU ops carry arbitrary results in the address field.
  assign is_load = m_q.reg_write && (GRF_WDsel == WD_MEM);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)                                    align_err <= 1'b0;
    else if ((m_q.mem_write || is_load) && !aligned) align_err <= 1'b1;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < DM_WORDS; i++) dm[i] <= '0;
    end else if (dm_we) begin
      dm[word_idx] <= dm_wdata;
    end
  end

  // PC+8 of a cleared register is still 4, so reset gates the bus directly.
  always_comb begin
    M_forward = '0;
    if (reset) begin
      case (GRF_WDsel)
        WD_ALU:  M_forward = m_q.result;
        WD_PC8:  M_forward = m_q.pcn + 32'd4;
        default: M_forward = '0;
      endcase
    end
  end

  assign result_M_o   = m_q.result;
  assign PCn_M_o      = m_q.pcn;
  assign OP_M_o       = m_q.op;
  assign A3_M_o       = m_q.a3;
  assign regWrite_M_o = m_q.reg_write;
  assign M_A3         = m_q.a3;
  assign M_regWrite   = m_q.reg_write;

endmodule

// File: tb/tb_m_stage.sv
module tb_m_stage;
  import m_stage_pkg::*;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [1:0]  GRF_WDsel = 2'b00;
  logic [31:0] W_forward = '0;
  logic [4:0]  W_A3 = '0;
  logic        W_regWrite = 1'b0;
  logic [31:0] memory_M_o, result_M_o, PCn_M_o, OP_M_o, M_forward, dm_addr, dm_wdata;
  logic [4:0]  A3_M_o, M_A3;
  logic        regWrite_M_o, M_regWrite, dm_we, align_err;

  int n_cmp = 0;
  int n_err = 0;

  m_stage_if e_if ();

  m_stage dut (
    .clk(clk), .reset(reset), .GRF_WDsel(GRF_WDsel), .e_if(e_if),
    .W_forward(W_forward), .W_A3(W_A3), .W_regWrite(W_regWrite),
    .memory_M_o(memory_M_o), .result_M_o(result_M_o), .PCn_M_o(PCn_M_o),
    .OP_M_o(OP_M_o), .A3_M_o(A3_M_o), .regWrite_M_o(regWrite_M_o),
    .M_forward(M_forward), .M_A3(M_A3), .M_regWrite(M_regWrite),
    .dm_we(dm_we), .dm_addr(dm_addr), .dm_wdata(dm_wdata), .align_err(align_err)
  );

  always #5 clk = ~clk;

  task automatic drive(input logic [31:0] res, rt, pcn, op, input logic [4:0] a3,
                       input logic rw, mw, input logic [1:0] mt, input logic ls);
    e_if.result_E_o = res;  e_if.rt_E_o = rt;  e_if.PCn_E_o = pcn;
    e_if.OP_E_o = op;       e_if.A3_E_o = a3;  e_if.regWrite_E_o = rw;
    e_if.memWrite_E_o = mw; e_if.memType_E_o = mt; e_if.loadSigned_E_o = ls;
  endtask

  task automatic bubble();
    drive('0, '0, '0, '0, '0, 1'b0, 1'b0, 2'b00, 1'b0);
  endtask

  // Advance one cycle; sample 1 time unit after the edge.
  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic test_store_load();
    GRF_WDsel = WD_MEM; W_regWrite = 1'b0;
    drive(32'h10, 32'h12345678, 32'h1004, 32'hAC000010, 5'd0, 1'b0, 1'b1, MT_W, 1'b0);
    step();
    n_cmp++; if (dm_we !== 1'b1) begin n_err++; $display("FAIL sw_we got %0b exp 1", dm_we); end
    n_cmp++; if (dm_wdata !== 32'h12345678) begin n_err++; $display("FAIL sw_wdata got %h exp 12345678", dm_wdata); end
    n_cmp++; if (dm_addr !== 32'h10) begin n_err++; $display("FAIL sw_addr got %h exp 00000010", dm_addr); end
    drive(32'h10, '0, 32'h1008, 32'h8C050010, 5'd5, 1'b1, 1'b0, MT_W, 1'b0);
    step();
    n_cmp++; if (memory_M_o !== 32'h12345678) begin n_err++; $display("FAIL lw_b2b got %h exp 12345678", memory_M_o); end
    n_cmp++; if (dm_we !== 1'b0) begin n_err++; $display("FAIL lw_we got %0b exp 0", dm_we); end
  endtask

  task automatic test_byte_half();
    drive(32'h12, 32'h000000AB, 32'h100C, 32'hA0000012, 5'd0, 1'b0, 1'b1, MT_B, 1'b0);
    step();
    n_cmp++; if (dm_wdata !== 32'h12AB5678) begin n_err++; $display("FAIL sb_merge got %h exp 12AB5678", dm_wdata); end
    drive(32'h12, '0, 32'h1010, 32'h80060012, 5'd6, 1'b1, 1'b0, MT_B, 1'b1);
    step();
    n_cmp++; if (memory_M_o !== 32'hFFFFFFAB) begin n_err++; $display("FAIL lb_signed got %h exp FFFFFFAB", memory_M_o); end
    drive(32'h12, '0, 32'h1014, 32'h94060012, 5'd6, 1'b1, 1'b0, MT_H, 1'b0);
    step();
    n_cmp++; if (memory_M_o !== 32'h000012AB) begin n_err++; $display("FAIL lhu got %h exp 000012AB", memory_M_o); end
    drive(32'h10, '0, 32'h1018, 32'h84060010, 5'd6, 1'b1, 1'b0, MT_H, 1'b1);
    step();
    n_cmp++; if (memory_M_o !== 32'h00005678) begin n_err++; $display("FAIL lh_low got %h exp 00005678", memory_M_o); end
  endtask

  task automatic test_store_fwd();
    drive(32'h40, '0, 32'h2004, 32'h8C080040, 5'd8, 1'b1, 1'b0, MT_W, 1'b0);
    step();
    drive(32'h20, 32'h11111111, 32'h2008, 32'hAC080020, 5'd0, 1'b0, 1'b1, MT_W, 1'b0);
    step();
    W_forward = 32'hCAFEBABE; W_A3 = 5'd8; W_regWrite = 1'b1; #1;
    n_cmp++; if (dm_wdata !== 32'hCAFEBABE) begin n_err++; $display("FAIL stfwd_wdata got %h exp CAFEBABE", dm_wdata); end
    drive(32'h20, '0, 32'h200C, 32'h8C090020, 5'd9, 1'b1, 1'b0, MT_W, 1'b0);
    step();
    W_regWrite = 1'b0; #1;
    n_cmp++; if (memory_M_o !== 32'hCAFEBABE) begin n_err++; $display("FAIL stfwd_rd got %h exp CAFEBABE", memory_M_o); end
    drive(32'h24, 32'h5555AAAA, 32'h2010, 32'hAC000024, 5'd0, 1'b0, 1'b1, MT_W, 1'b0);
    step();
    W_forward = 32'hCAFEBABE; W_A3 = 5'd0; W_regWrite = 1'b1; #1;
    n_cmp++; if (dm_wdata !== 32'h5555AAAA) begin n_err++; $display("FAIL stfwd_r0 got %h exp 5555AAAA", dm_wdata); end
    drive(32'h24, '0, 32'h2014, 32'h8C090024, 5'd9, 1'b1, 1'b0, MT_W, 1'b0);
    step();
    W_regWrite = 1'b0; #1;
    n_cmp++; if (memory_M_o !== 32'h5555AAAA) begin n_err++; $display("FAIL stfwd_r0_rd got %h exp 5555AAAA", memory_M_o); end
  endtask

  task automatic test_range();
    drive(32'h2FFC, 32'h0BADF00D, '0, '0, 5'd0, 1'b0, 1'b1, MT_W, 1'b0);
    step();
    n_cmp++; if (dm_we !== 1'b1) begin n_err++; $display("FAIL top_word_we got %0b exp 1", dm_we); end
    drive(32'h2FFC, '0, '0, '0, 5'd4, 1'b1, 1'b0, MT_RSV, 1'b0);
    step();
    n_cmp++; if (memory_M_o !== 32'h0BADF00D) begin n_err++; $display("FAIL top_word_rd got %h exp 0BADF00D", memory_M_o); end
    drive(32'h3000, 32'h11223344, '0, '0, 5'd0, 1'b0, 1'b1, MT_W, 1'b0);
    step();
    n_cmp++; if (dm_we !== 1'b0) begin n_err++; $display("FAIL oor_we got %0b exp 0", dm_we); end
    drive(32'h3000, '0, '0, '0, 5'd4, 1'b1, 1'b0, MT_W, 1'b0);
    step();
    n_cmp++; if (memory_M_o !== 32'h0) begin n_err++; $display("FAIL oor_rd got %h exp 0", memory_M_o); end
    n_cmp++; if (align_err !== 1'b0) begin n_err++; $display("FAIL oor_noerr got %0b exp 0", align_err); end
  endtask

  task automatic test_align();
    drive(32'h22, 32'hDEADDEAD, '0, '0, 5'd0, 1'b0, 1'b1, MT_W, 1'b0);
    step();
    n_cmp++; if (dm_we !== 1'b0) begin n_err++; $display("FAIL mis_we got %0b exp 0", dm_we); end
    drive(32'h20, '0, '0, '0, 5'd4, 1'b1, 1'b0, MT_W, 1'b0);
    step();
    n_cmp++; if (align_err !== 1'b1) begin n_err++; $display("FAIL mis_flag got %0b exp 1", align_err); end
    n_cmp++; if (memory_M_o !== 32'hCAFEBABE) begin n_err++; $display("FAIL mis_nowrite got %h exp CAFEBABE", memory_M_o); end
    drive(32'h13, '0, '0, '0, 5'd4, 1'b1, 1'b0, MT_H, 1'b0);
    step();
    n_cmp++; if (memory_M_o !== 32'h0) begin n_err++; $display("FAIL mis_lh got %h exp 0", memory_M_o); end
    bubble();
    step();
    n_cmp++; if (align_err !== 1'b1) begin n_err++; $display("FAIL mis_sticky got %0b exp 1", align_err); end
  endtask

  task automatic test_forward_bus();
    drive(32'h77, '0, 32'h3004, 32'h0C000000, 5'd31, 1'b1, 1'b0, MT_W, 1'b0);
    step();
    GRF_WDsel = WD_PC8; #1;
    n_cmp++; if (M_forward !== 32'h3008) begin n_err++; $display("FAIL fwd_pc8 got %h exp 00003008", M_forward); end
    n_cmp++; if (M_A3 !== 5'd31 || M_regWrite !== 1'b1) begin n_err++; $display("FAIL fwd_a3 got %0d/%0b exp 31/1", M_A3, M_regWrite); end
    GRF_WDsel = WD_ALU; #1;
    n_cmp++; if (M_forward !== 32'h77) begin n_err++; $display("FAIL fwd_alu got %h exp 00000077", M_forward); end
    GRF_WDsel = WD_MEM; #1;
    n_cmp++; if (M_forward !== 32'h0) begin n_err++; $display("FAIL fwd_mem got %h exp 0", M_forward); end
    bubble();
  endtask

  task automatic test_reset();
    GRF_WDsel = WD_ALU;
    drive(32'h0, 32'h99999999, 32'h4004, 32'hAC000000, 5'd7, 1'b1, 1'b1, MT_W, 1'b0);
    step();
    #2 reset = 1'b0; #1;
    n_cmp++; if (result_M_o !== '0 || PCn_M_o !== '0 || OP_M_o !== '0) begin n_err++; $display("FAIL rst_fields got %h/%h/%h exp 0", result_M_o, PCn_M_o, OP_M_o); end
    n_cmp++; if (A3_M_o !== '0 || regWrite_M_o !== 1'b0 || M_regWrite !== 1'b0) begin n_err++; $display("FAIL rst_ctl got %0d/%0b/%0b exp 0", A3_M_o, regWrite_M_o, M_regWrite); end
    n_cmp++; if (dm_we !== 1'b0 || align_err !== 1'b0) begin n_err++; $display("FAIL rst_flags got %0b/%0b exp 0", dm_we, align_err); end
    n_cmp++; if (memory_M_o !== '0) begin n_err++; $display("FAIL rst_mem got %h exp 0", memory_M_o); end
    GRF_WDsel = WD_PC8; #1;
    n_cmp++; if (M_forward !== '0) begin n_err++; $display("FAIL rst_fwd got %h exp 0", M_forward); end
    GRF_WDsel = WD_MEM;
    bubble();
    @(posedge clk); #2 reset = 1'b1;
    drive(32'h10, '0, '0, '0, 5'd4, 1'b1, 1'b0, MT_W, 1'b0);
    step();
    n_cmp++; if (memory_M_o !== '0) begin n_err++; $display("FAIL rst_dm_clr got %h exp 0", memory_M_o); end
    drive(32'h0, '0, '0, '0, 5'd4, 1'b1, 1'b0, MT_W, 1'b0);
    step();
    n_cmp++; if (memory_M_o !== '0) begin n_err++; $display("FAIL rst_st_drop got %h exp 0", memory_M_o); end
  endtask

  initial begin
    bubble();
    #12 reset = 1'b1;
    test_store_load();
    test_byte_half();
    test_store_fwd();
    test_range();
    test_align();
    test_forward_bus();
    test_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
